// File: rtl/money_counter.sv
// Deposit-side note counter: arms on drawer open, accumulates validated notes,
// and reports the session total to the ATM control unit as a one-cycle valid pulse.
module money_counter #(
   parameter int unsigned BALANCE_WIDTH  = 16,
   parameter int unsigned MAX_NOTES      = 40,
   parameter int unsigned NOTES_WIDTH    = $clog2(MAX_NOTES + 1),
   parameter int unsigned TIMEOUT_CYCLES = 1000,
   parameter int unsigned TIMEOUT_WIDTH  = $clog2(TIMEOUT_CYCLES)
) (
   input  logic                     clk,
   input  logic                     RST,
   input  logic                     In_Drawer_En,
   input  logic                     In_Note_Valid,
   input  logic [2:0]               In_Note_Denom,
   input  logic                     In_Note_Fake,
   output logic                     Out_Money_Counter_Valid,
   output logic [BALANCE_WIDTH-1:0] Out_Money_Counter_Amount,
   output logic                     Out_Reject_Note,
   output logic                     Out_Overflow
);

   localparam int unsigned SUM_W = BALANCE_WIDTH + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_COUNT,
      S_REPORT,
      S_WAIT_CLOSE
   } state_t;

   state_t                   r_state, w_state_nxt;
   logic [BALANCE_WIDTH-1:0] r_amount, w_amount_nxt;
   logic [NOTES_WIDTH-1:0]   r_notes, w_notes_nxt;
   logic [TIMEOUT_WIDTH-1:0] r_timer, w_timer_nxt;
   logic                     r_valid, w_valid_nxt;
   logic                     r_reject, w_reject_nxt;
   logic                     r_ovf, w_ovf_nxt;

   logic [6:0]               w_note_value;
   logic [SUM_W-1:0]         w_sum;
   logic                     w_bad_note;
   logic                     w_count_full;
   logic                     w_sum_ovf;
   logic                     w_timeout;

   // Denomination code to face value; invalid codes map to 0 and are rejected anyway.
   always_comb begin
      w_note_value = 7'd0;
      case (In_Note_Denom)
         3'd0:    w_note_value = 7'd1;
         3'd1:    w_note_value = 7'd5;
         3'd2:    w_note_value = 7'd10;
         3'd3:    w_note_value = 7'd20;
         3'd4:    w_note_value = 7'd50;
         3'd5:    w_note_value = 7'd100;
         default: w_note_value = 7'd0;
      endcase
   end

   // Sum carried one bit wider so a would-be wrap shows up as the top bit.
   assign w_bad_note   = In_Note_Fake | (In_Note_Denom > 3'd5);
   assign w_sum        = {1'b0, r_amount} + SUM_W'(w_note_value);
   assign w_sum_ovf    = w_sum[BALANCE_WIDTH];
   assign w_count_full = (r_notes == NOTES_WIDTH'(MAX_NOTES));
   assign w_timeout    = (r_timer == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));

   always_comb begin
      w_state_nxt  = r_state;
      w_amount_nxt = r_amount;
      w_notes_nxt  = r_notes;
      w_timer_nxt  = r_timer;
      w_valid_nxt  = 1'b0;
      w_reject_nxt = 1'b0;
      w_ovf_nxt    = r_ovf;

      case (r_state)
         S_IDLE: begin
            w_reject_nxt = In_Note_Valid;
            if (In_Drawer_En) begin
               w_state_nxt  = S_COUNT;
               w_amount_nxt = '0;
               w_notes_nxt  = '0;
               w_timer_nxt  = '0;
               w_ovf_nxt    = 1'b0;
            end
         end

         S_COUNT: begin
            if (In_Note_Valid) begin
               w_timer_nxt = '0;
               if (w_bad_note) begin
                  w_reject_nxt = 1'b1;
               end else if (w_count_full || w_sum_ovf) begin
                  w_reject_nxt = 1'b1;
                  w_ovf_nxt    = 1'b1;
               end else begin
                  w_amount_nxt = w_sum[BALANCE_WIDTH-1:0];
                  w_notes_nxt  = r_notes + NOTES_WIDTH'(1);
               end
            end else if (!w_timeout) begin
               w_timer_nxt = r_timer + TIMEOUT_WIDTH'(1);
            end
            // A note arriving with the close is counted before the report.
            if (!In_Drawer_En || (!In_Note_Valid && w_timeout)) begin
               w_state_nxt = S_REPORT;
               w_valid_nxt = 1'b1;
            end
         end

         S_REPORT: begin
            w_reject_nxt = In_Note_Valid;
            w_state_nxt  = S_WAIT_CLOSE;
         end

         S_WAIT_CLOSE: begin
            w_reject_nxt = In_Note_Valid;
            if (!In_Drawer_En) begin
               w_state_nxt = S_IDLE;
            end
         end

         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         r_amount <= '0;
         r_notes  <= '0;
         r_timer  <= '0;
         r_valid  <= 1'b0;
         r_reject <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         r_amount <= w_amount_nxt;
         r_notes  <= w_notes_nxt;
         r_timer  <= w_timer_nxt;
         r_valid  <= w_valid_nxt;
         r_reject <= w_reject_nxt;
         r_ovf    <= w_ovf_nxt;
      end
   end

   assign Out_Money_Counter_Valid  = r_valid;
   assign Out_Money_Counter_Amount = r_amount;
   assign Out_Reject_Note          = r_reject;
   assign Out_Overflow             = r_ovf;

endmodule

// File: tb/tb_money_counter.sv
// Scoreboard bench for money_counter: a session-level reference model queues expected
// report/reject pulses, and a negedge monitor pops and compares them as the DUT emits them.
module tb_money_counter;

   localparam int unsigned BW   = 8;
   localparam int unsigned MAXN = 4;
   localparam int unsigned TMO  = 12;

   logic          clk = 1'b0;
   logic          rst;
   logic          drawer;
   logic          nv;
   logic [2:0]    denom;
   logic          fake;
   logic          o_valid;
   logic [BW-1:0] o_amount;
   logic          o_reject;
   logic          o_ovf;

   always #5 clk = ~clk;

   money_counter #(
      .BALANCE_WIDTH  (BW),
      .MAX_NOTES      (MAXN),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk                      (clk),
      .RST                      (rst),
      .In_Drawer_En             (drawer),
      .In_Note_Valid            (nv),
      .In_Note_Denom            (denom),
      .In_Note_Fake             (fake),
      .Out_Money_Counter_Valid  (o_valid),
      .Out_Money_Counter_Amount (o_amount),
      .Out_Reject_Note          (o_reject),
      .Out_Overflow             (o_ovf)
   );

   typedef struct {
      int stamp;
      int amount;
      bit ovf;
   } exp_t;

   typedef enum int {P_CLOSED, P_OPEN, P_REPORTING, P_AWAIT_CLOSE} phase_t;

   exp_t   rep_q[$];
   exp_t   rej_q[$];
   int     checks   = 0;
   int     failures = 0;
   int     edge_no  = 0;

   // Session-level reference state.
   phase_t m_phase = P_CLOSED;
   int     m_total = 0;
   int     m_notes = 0;
   int     m_quiet = 0;
   bit     m_ovf   = 1'b0;
   int     note_val [6] = '{1, 5, 10, 20, 50, 100};

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_no);
      end
   endtask

   // Predict the effect of the coming clock edge given the inputs now applied.
   task automatic model_edge(input bit r, input bit d, input bit v, input int code, input bit f);
      exp_t e;
      bit   rej = 1'b0;
      bit   rep = 1'b0;
      e.stamp = edge_no + 1;
      if (r) begin
         m_phase = P_CLOSED;
         m_total = 0;
         m_notes = 0;
         m_quiet = 0;
         m_ovf   = 1'b0;
         return;
      end
      case (m_phase)
         P_CLOSED: begin
            rej = v;
            if (d) begin
               m_phase = P_OPEN;
               m_total = 0;
               m_notes = 0;
               m_quiet = 0;
               m_ovf   = 1'b0;
            end
         end
         P_OPEN: begin
            if (v) begin
               m_quiet = 0;
               if (f || code > 5) begin
                  rej = 1'b1;
               end else if (m_notes >= int'(MAXN)) begin
                  rej   = 1'b1;
                  m_ovf = 1'b1;
               end else if (m_total + note_val[code] > (1 << BW) - 1) begin
                  rej   = 1'b1;
                  m_ovf = 1'b1;
               end else begin
                  m_total += note_val[code];
                  m_notes++;
               end
            end else begin
               m_quiet++;
            end
            if (!d || m_quiet == int'(TMO)) begin
               rep     = 1'b1;
               m_phase = P_REPORTING;
            end
         end
         P_REPORTING: begin
            rej     = v;
            m_phase = P_AWAIT_CLOSE;
         end
         default: begin
            rej = v;
            if (!d) m_phase = P_CLOSED;
         end
      endcase
      e.amount = m_total;
      e.ovf    = m_ovf;
      if (rej) rej_q.push_back(e);
      if (rep) rep_q.push_back(e);
   endtask

   task automatic step(input bit r, input bit d, input bit v, input int code, input bit f);
      rst    = r;
      drawer = d;
      nv     = v;
      denom  = 3'(code);
      fake   = f;
      model_edge(r, d, v, code, f);
      @(posedge clk);
      edge_no++;
      #1;
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_valid"},  int'(o_valid),  0);
      check({tag, "_amount"}, int'(o_amount), 0);
      check({tag, "_reject"}, int'(o_reject), 0);
      check({tag, "_ovf"},    int'(o_ovf),    0);
   endtask

   // Monitor: pop and compare on every output pulse; anything overdue was missed.
   always @(negedge clk) begin
      exp_t e;
      if (o_valid) begin
         if (rep_q.size() == 0) begin
            check("unexpected_valid", 1, 0);
         end else begin
            e = rep_q.pop_front();
            check("valid_edge",    edge_no,        e.stamp);
            check("report_amount", int'(o_amount), e.amount);
            check("report_ovf",    int'(o_ovf),    int'(e.ovf));
         end
      end
      if (o_reject) begin
         if (rej_q.size() == 0) begin
            check("unexpected_reject", 1, 0);
         end else begin
            e = rej_q.pop_front();
            check("reject_edge",   edge_no,        e.stamp);
            check("reject_amount", int'(o_amount), e.amount);
            check("reject_ovf",    int'(o_ovf),    int'(e.ovf));
         end
      end
      while (rep_q.size() > 0 && rep_q[0].stamp <= edge_no) begin
         e = rep_q.pop_front();
         check("missing_valid_edge", edge_no, e.stamp);
      end
      while (rej_q.size() > 0 && rej_q[0].stamp <= edge_no) begin
         e = rej_q.pop_front();
         check("missing_reject_edge", edge_no, e.stamp);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, edge %0d", edge_no);
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit dr;
      bit rr;
      bit vv;
      rst    = 1'b1;
      drawer = 1'b0;
      nv     = 1'b0;
      denom  = 3'd0;
      fake   = 1'b0;
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      check_zero_outputs("reset");

      // Three valid notes then close: one report of 170.
      step(0, 1, 0, 0, 0);
      step(0, 1, 1, 5, 0);
      step(0, 1, 1, 4, 0);
      step(0, 1, 1, 3, 0);
      step(0, 1, 0, 0, 0);
      check("amount_after_notes", int'(o_amount), 170);
      step(0, 0, 0, 0, 0);
      repeat (3) step(0, 0, 0, 0, 0);

      // Invalid code and counterfeit note are returned.
      step(0, 1, 0, 0, 0);
      step(0, 1, 1, 7, 0);
      step(0, 1, 0, 0, 0);
      step(0, 1, 1, 2, 1);
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      repeat (3) step(0, 0, 0, 0, 0);

      // Third 100 would exceed 8-bit balance.
      step(0, 1, 0, 0, 0);
      repeat (3) step(0, 1, 1, 5, 0);
      step(0, 1, 0, 0, 0);
      check("overflow_sticky", int'(o_ovf), 1);
      step(0, 0, 0, 0, 0);
      repeat (3) step(0, 0, 0, 0, 0);

      // Note-count limit; close coincides with a note.
      step(0, 1, 0, 0, 0);
      repeat (4) step(0, 1, 1, 0, 0);
      step(0, 0, 1, 0, 0);
      repeat (3) step(0, 0, 0, 0, 0);

      // Timeout with drawer held high, then no re-arm until drawer cycles.
      step(0, 1, 0, 0, 0);
      step(0, 1, 1, 1, 0);
      repeat (30) step(0, 1, 0, 0, 0);
      step(0, 1, 1, 3, 0);
      step(0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      step(0, 1, 1, 2, 0);
      step(0, 0, 0, 0, 0);
      repeat (3) step(0, 0, 0, 0, 0);

      // Reset mid-session with drawer still high, then a note while idle.
      step(0, 1, 0, 0, 0);
      step(0, 1, 1, 3, 0);
      step(0, 1, 1, 2, 0);
      step(0, 1, 0, 0, 0);
      check("amount_before_reset", int'(o_amount), 30);
      step(1, 1, 0, 0, 0);
      check_zero_outputs("mid_reset");
      step(0, 1, 1, 0, 0);
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      repeat (3) step(0, 0, 0, 0, 0);
      step(0, 0, 1, 2, 0);
      step(0, 0, 0, 0, 0);

      // Randomized traffic with alternating busy and sparse note phases.
      dr = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 29) == 0) dr = !dr;
         rr = ($urandom_range(0, 599) == 0);
         if ((i % 500) < 250) vv = ($urandom_range(0, 2) == 0);
         else                 vv = ($urandom_range(0, 19) == 0);
         step(rr, dr, vv, int'($urandom_range(0, 7)), $urandom_range(0, 9) == 0);
      end

      repeat (20) step(0, 0, 0, 0, 0);
      check("pending_reports", rep_q.size(), 0);
      check("pending_rejects", rej_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
